// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef logic [31:0] regval_t;

  localparam int unsigned WORD_BYTES = 4;

  // One buffered fetch: the address it came from and the word returned.
  typedef struct packed {
    regval_t pc;
    regval_t word;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of any incoming PC are dropped.
  function automatic regval_t word_align(input regval_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, word} entries with a single-cycle clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  ptr_t         wr_ptr_q, wr_ptr_d;
  ptr_t         rd_ptr_q, rd_ptr_d;
  logic [AW:0]  count_q, count_d;
  logic         do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Clear wins over push/pop; a push into a full FIFO is refused.
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + ptr_t'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Overflow is a protocol error of the producer.
  always_ff @(posedge clock) begin
    if (!reset && !clear && push) begin
      assert (!full);
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: issues sequential word reads, tags returning words
// with their PC, buffers them and hands one {pc, instruction} per cycle to decode.
module fetch
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter regval_t     RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic        mem_wait_request,
  input  logic        mem_read_data_valid,
  input  logic [31:0] mem_read_data,
  input  logic        hold,
  input  logic        is_pc_changing,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        is_valid,
  output logic [31:0] pc,
  output logic [31:0] instruction
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIMIT = (CW + 1)'(DEPTH);

  typedef logic [CW-1:0] cnt_t;

  // Architectural state.
  regval_t fetch_pc_q, fetch_pc_d;
  cnt_t    outstanding_q, outstanding_d;
  cnt_t    drop_q, drop_d;
  logic    is_valid_q, is_valid_d;
  regval_t pc_q, pc_d;
  regval_t instruction_q, instruction_d;

  // Data FIFO (returned words with their PCs).
  fetch_entry_t data_in, data_head;
  cnt_t         data_count;
  logic         data_empty, data_full;
  logic         data_push, data_pop;

  // PC-tag queue (one entry per in-flight read that will be kept).
  fetch_entry_t tag_in, tag_head;
  cnt_t         tag_count;
  logic         tag_empty, tag_full;
  logic         tag_push, tag_pop;

  logic       accept;
  logic       keep_word;
  logic [CW:0] in_use;

  // Reads in flight plus words already buffered may never exceed DEPTH,
  // which is what keeps the data FIFO from overflowing.
  assign in_use   = {1'b0, outstanding_q} + {1'b0, data_count};
  assign mem_read = !reset && !redirect && !is_pc_changing && (in_use < DEPTH_LIMIT);
  assign mem_address = fetch_pc_q;
  assign accept   = mem_read && !mem_wait_request;

  // A response is kept only when no stale (pre-redirect) reads remain ahead of it.
  assign keep_word = mem_read_data_valid && (drop_q == '0);

  assign tag_in    = {fetch_pc_q, 32'h0};
  assign tag_push  = accept;
  assign tag_pop   = keep_word;

  assign data_in   = {tag_head.pc, mem_read_data};
  assign data_push = keep_word && !redirect;
  assign data_pop  = !redirect && !hold && !data_empty;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect),
    .push      (data_push),
    .push_data (data_in),
    .pop       (data_pop),
    .head      (data_head),
    .count     (data_count),
    .empty     (data_empty),
    .full      (data_full)
  );

  // Tags of reads outstanding at a redirect are discarded with the clear;
  // those reads are then accounted for by the drop counter instead.
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect),
    .push      (tag_push),
    .push_data (tag_in),
    .pop       (tag_pop),
    .head      (tag_head),
    .count     (tag_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  // Fetch PC, outstanding-read and stale-read accounting; redirect overrides.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + regval_t'(WORD_BYTES);
    end

    if (accept && !mem_read_data_valid) begin
      outstanding_d = outstanding_q + cnt_t'(1);
    end else if (!accept && mem_read_data_valid && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - cnt_t'(1);
    end

    if (mem_read_data_valid && (drop_q != '0)) begin
      drop_d = drop_q - cnt_t'(1);
    end

    // Every read still in flight after this cycle belongs to the old path.
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
      drop_d     = outstanding_d;
    end
  end

  // Decode-facing output registers: load the FIFO head unless held.
  always_comb begin
    is_valid_d    = is_valid_q;
    pc_d          = pc_q;
    instruction_d = instruction_q;
    if (redirect) begin
      is_valid_d = 1'b0;
    end else if (!hold) begin
      is_valid_d = !data_empty;
      if (!data_empty) begin
        pc_d          = data_head.pc;
        instruction_d = data_head.word;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      is_valid_q    <= 1'b0;
      pc_q          <= '0;
      instruction_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      is_valid_q    <= is_valid_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
    end
  end

  assign is_valid    = is_valid_q;
  assign pc          = pc_q;
  assign instruction = instruction_q;

  // Flags and the tied-off word lane of the tag queue are only needed by the checks below.
  logic unused_status;
  assign unused_status = ^{tag_head.word, tag_full, data_full, tag_count};

  // Bookkeeping invariants of the memory protocol.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(mem_read_data_valid && (outstanding_q == '0)));
      assert (!(keep_word && tag_empty));
      assert (!(accept && tag_full));
      assert (!(data_push && data_full));
      assert (({1'b0, tag_count} + {1'b0, drop_q}) == {1'b0, outstanding_q});
    end
  end

endmodule
